// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N-channel selector.
package mux_scan_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Round-robin successor that never lands on codes at or above channels.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned channels);
    return (ptr + 1 >= channels) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_nbit_core.sv
// Combinational CHANNELS:1 selector of WIDTH-bit lanes with an in-range flag.
module mux_nbit_core #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          q_c,
  output logic                      in_range_c
);

  always_comb begin
    q_c        = '0;
    in_range_c = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        q_c        = data[k*WIDTH +: WIDTH];
        in_range_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nbit_scan.sv
// Registered N-channel selector with MANUAL select and round-robin SCAN modes.
// Optional channel skipping via MASK is enabled by defining MUX_SCAN_SKIP_EN.
module mux_nbit_scan
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          S,
  input  logic                      MODE,
  input  logic                      HOLD,
  input  logic [DWELL_W-1:0]        DWELL,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [CHANNELS-1:0]       MASK,
`endif
  output logic [WIDTH-1:0]          O,
  output logic [SEL_W-1:0]          CH,
  output logic                      VALID,
  output logic                      ERR,
  output logic                      STEP
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt, cur_ptr, adv_ptr, first_ptr, core_sel, ch_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]   o_nxt, core_q;
  logic               valid_nxt, err_nxt, step_nxt;
  logic               core_ok, s_enabled, any_enabled;

`ifdef MUX_SCAN_SKIP_EN
  // Lowest enabled channel, next enabled channel above cur_ptr (wrapping), and S enable.
  always_comb begin
    first_ptr = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (MASK[k]) first_ptr = SEL_W'(k);
    end
  end

  always_comb begin
    adv_ptr   = first_ptr;
    s_enabled = 1'b0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (MASK[k] && (SEL_W'(k) > cur_ptr)) adv_ptr = SEL_W'(k);
      if (SEL_W'(k) == S) s_enabled = MASK[k];
    end
  end

  assign any_enabled = |MASK;
`else
  assign first_ptr   = '0;
  assign adv_ptr     = SEL_W'(next_ptr(32'(cur_ptr), CHANNELS));
  assign s_enabled   = 1'b1;
  assign any_enabled = 1'b1;
`endif

  // On the first SCAN cycle the stale pointer is ignored and the scan starts fresh.
  assign cur_ptr  = (state == SCAN) ? ptr : first_ptr;
  assign core_sel = (MODE == MODE_SCAN) ? cur_ptr : S;

  mux_nbit_core #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_core (
    .data       (I),
    .sel        (core_sel),
    .q_c        (core_q),
    .in_range_c (core_ok)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= MANUAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!HOLD) state_nxt = (MODE == MODE_SCAN) ? SCAN : MANUAL;
  end

  always_comb begin
    o_nxt     = O;
    ch_nxt    = CH;
    valid_nxt = VALID;
    err_nxt   = ERR;
    step_nxt  = 1'b0;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (!HOLD) begin
      if (MODE == MODE_MANUAL) begin
        ptr_nxt = '0;
        cnt_nxt = '0;
        if (core_ok && s_enabled) begin
          o_nxt     = core_q;
          ch_nxt    = S;
          valid_nxt = 1'b1;
          err_nxt   = 1'b0;
        end else begin
          valid_nxt = 1'b0;
          err_nxt   = 1'b1;
        end
      end else if (!any_enabled) begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
      end else begin
        o_nxt     = core_q;
        ch_nxt    = cur_ptr;
        valid_nxt = 1'b1;
        err_nxt   = 1'b0;
        ptr_nxt   = cur_ptr;
        // >= so that a DWELL lowered below the running count still advances.
        if (cnt >= DWELL) begin
          cnt_nxt  = '0;
          ptr_nxt  = adv_ptr;
          step_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + DWELL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= '0;
      cnt   <= '0;
      O     <= '0;
      CH    <= '0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      STEP  <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      O     <= o_nxt;
      CH    <= ch_nxt;
      VALID <= valid_nxt;
      ERR   <= err_nxt;
      STEP  <= step_nxt;
    end
  end

endmodule

// File: tb/tb_mux_nbit_scan.sv
// Scoreboard bench for mux_nbit_scan: stimulus queues expected outputs, a monitor compares them.
module tb_mux_nbit_scan;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned CHANNELS = 5;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned DWELL_W  = 8;

  logic                      CLK = 1'b0;
  logic                      RST = 1'b1;
  logic [CHANNELS*WIDTH-1:0] I;
  logic [SEL_W-1:0]          S;
  logic                      MODE;
  logic                      HOLD;
  logic [DWELL_W-1:0]        DWELL;
`ifdef MUX_SCAN_SKIP_EN
  logic [CHANNELS-1:0]       MASK = '1;
`endif
  logic [WIDTH-1:0]          O;
  logic [SEL_W-1:0]          CH;
  logic                      VALID;
  logic                      ERR;
  logic                      STEP;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] o;
    logic [SEL_W-1:0] ch;
    logic             valid;
    logic             err;
    logic             step;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [CHANNELS*WIDTH-1:0] I_RAMP = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [CHANNELS*WIDTH-1:0] I_MAN  = {3'd4, 3'd3, 3'd5, 3'd1, 3'd0};

  always #5 CLK = ~CLK;

  mux_nbit_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL_W  (DWELL_W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .I     (I),
    .S     (S),
    .MODE  (MODE),
    .HOLD  (HOLD),
    .DWELL (DWELL),
`ifdef MUX_SCAN_SKIP_EN
    .MASK  (MASK),
`endif
    .O     (O),
    .CH    (CH),
    .VALID (VALID),
    .ERR   (ERR),
    .STEP  (STEP)
  );

  task automatic check(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, fld, act, exp, $time);
  endtask

  // Queue the response expected at the next clock (or reset) event, then move to the next negedge.
  task automatic cyc(input string tag, input logic [WIDTH-1:0] o, input logic [SEL_W-1:0] ch,
                     input logic v, input logic e, input logic s);
    exp_t x;
    x = '{tag, o, ch, v, e, s};
    sb.push_back(x);
    @(negedge CLK);
  endtask

  // Monitor: compare after every rising clock or reset edge that has a pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK or posedge RST);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, "O",     8'(O),     8'(e.o));
        check(e.tag, "CH",    8'(CH),    8'(e.ch));
        check(e.tag, "VALID", 8'(VALID), 8'(e.valid));
        check(e.tag, "ERR",   8'(ERR),   8'(e.err));
        check(e.tag, "STEP",  8'(STEP),  8'(e.step));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    I = I_RAMP; S = '0; MODE = 1'b0; HOLD = 1'b0; DWELL = '0;
    @(negedge CLK);
    cyc("rst", 0, 0, 0, 0, 0);

    // MANUAL selects, including out-of-range codes
    RST = 1'b0; I = I_MAN;
    S = 3'd2; cyc("man_s2",  5, 2, 1, 0, 0);
    S = 3'd6; cyc("man_s6",  5, 2, 0, 1, 0);
    S = 3'd4; cyc("man_s4",  4, 4, 1, 0, 0);
    S = 3'd5; cyc("man_s5",  4, 4, 0, 1, 0);
    S = 3'd0; cyc("man_s0",  0, 0, 1, 0, 0);
    S = 3'd7; cyc("man_s7",  0, 0, 0, 1, 0);

    // SCAN with DWELL=2: each channel three cycles, STEP on the last
    I = I_RAMP; MODE = 1'b1; DWELL = 8'd2;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 3; r++)
        cyc("scan_d2", WIDTH'(c), SEL_W'(c), 1, 0, (r == 2));
    cyc("scan_d2_wrap", 0, 0, 1, 0, 0);

    MODE = 1'b0; S = 3'd3;
    cyc("back_man", 3, 3, 1, 0, 0);

    // SCAN with DWELL=0: advance every cycle
    MODE = 1'b1; DWELL = 8'd0;
    cyc("scan_d0", 0, 0, 1, 0, 1);
    cyc("scan_d0", 1, 1, 1, 0, 1);
    cyc("scan_d0", 2, 2, 1, 0, 1);
    cyc("scan_d0", 3, 3, 1, 0, 1);
    cyc("scan_d0", 4, 4, 1, 0, 1);
    cyc("scan_d0", 0, 0, 1, 0, 1);

    // HOLD at CH=3 with cnt=1, then resume the remaining dwell
    MODE = 1'b0; S = 3'd0;
    cyc("man_pre_hold", 0, 0, 1, 0, 0);
    MODE = 1'b1; DWELL = 8'd2;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        cyc("scan_to3", WIDTH'(c), SEL_W'(c), 1, 0, (r == 2));
    cyc("scan_at3", 3, 3, 1, 0, 0);
    HOLD = 1'b1;
    repeat (4) cyc("hold", 3, 3, 1, 0, 0);
    HOLD = 1'b0;
    cyc("resume", 3, 3, 1, 0, 0);
    cyc("resume", 3, 3, 1, 0, 1);
    cyc("resume", 4, 4, 1, 0, 0);

    // DWELL lowered below the running count advances right away
    DWELL = 8'd0;
    cyc("dwell_drop", 4, 4, 1, 0, 1);
    cyc("dwell_drop", 0, 0, 1, 0, 1);
    cyc("dwell_drop", 1, 1, 1, 0, 1);
    cyc("dwell_drop", 2, 2, 1, 0, 1);
    DWELL = 8'd3;
    cyc("at_ptr3", 3, 3, 1, 0, 0);

    // Asynchronous reset mid-scan, then restart from channel 0
    sb.push_back('{"async_rst", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    RST = 1'b1;
    @(negedge CLK);
    cyc("in_rst", 0, 0, 0, 0, 0);
    RST = 1'b0;
    cyc("post_rst", 0, 0, 1, 0, 0);
    cyc("post_rst", 0, 0, 1, 0, 0);

`ifdef MUX_SCAN_SKIP_EN
    MODE = 1'b0; S = 3'd0;
    cyc("skip_pre", 0, 0, 1, 0, 0);
    MASK = 5'b10101; MODE = 1'b1; DWELL = 8'd0;
    cyc("skip", 0, 0, 1, 0, 1);
    cyc("skip", 2, 2, 1, 0, 1);
    cyc("skip", 4, 4, 1, 0, 1);
    cyc("skip", 0, 0, 1, 0, 1);
    MASK = '0;
    cyc("skip_none", 0, 0, 0, 0, 0);
`endif

    // Every queued expectation must have been consumed by the monitor
    repeat (4) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nbit_scan.md
Name: mux_nbit_scan

Overview:
- Parametrised, registered N-channel, W-bit selector; next generation of the 3-bit 5-to-1 combinational mux.
- Two modes:
  - MANUAL: the channel is picked by S.
  - SCAN: the channel is stepped automatically, round-robin, with a programmable dwell time.
- Registered output with VALID/ERR flags.
- Feeds display/readout logic that needs either a fixed channel or a rotating channel.

Parameters:
- WIDTH, 3, bits per channel
- CHANNELS, 5, number of input channels (2..64)
- SEL_W, 3, select/pointer width; must satisfy 2**SEL_W >= CHANNELS
- DWELL_W, 8, width of dwell-count input and counter

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- I  in  CHANNELS*WIDTH  flat input bus; channel k = I[k*WIDTH +: WIDTH]
- S  in  SEL_W  channel select, used in MANUAL
- MODE  in  1  0 = MANUAL, 1 = SCAN
- HOLD  in  1  freezes O, CH, pointer and dwell counter
- DWELL  in  DWELL_W  cycles to stay on a channel in SCAN, minus one
- O  out  WIDTH  registered selected data
- CH  out  SEL_W  channel index currently driving O
- VALID  out  1  O holds a legal channel's data
- ERR  out  1  MANUAL select out of range (S >= CHANNELS)
- STEP  out  1  one-cycle pulse when SCAN advances the pointer

Behaviour:
- Reset (asynchronous, RST=1): O=0, CH=0, VALID=0, ERR=0, STEP=0, pointer=0, dwell cnt=0, state=MANUAL.
  - Reset asserted mid-scan aborts immediately.
  - After release, the block resumes from channel 0 in whichever mode MODE selects.
- FSM states are MANUAL and SCAN; the next state follows MODE every cycle, with HOLD having priority.
- Priority order: RST > HOLD > mode behaviour.
  - HOLD=1: all registers keep their value; STEP=0.
- MANUAL, latency 1 cycle:
  - S < CHANNELS: O<=I[S], CH<=S, VALID<=1, ERR<=0.
  - S >= CHANNELS: O and CH hold, VALID<=0, ERR<=1.
  - STEP=0; dwell cnt cleared.
- Entering SCAN (MANUAL->SCAN): pointer<=0, cnt<=0; the first SCAN cycle outputs channel 0.
- SCAN, each cycle:
  - O<=I[pointer], CH<=pointer, VALID<=1, ERR<=0.
  - cnt == DWELL: cnt<=0, pointer<=pointer+1, STEP<=1.
  - Otherwise: cnt<=cnt+1, STEP<=0.
  - Wrap: the pointer goes from CHANNELS-1 to 0, never to the unused codes CHANNELS..2**SEL_W-1.
  - DWELL=0: the pointer advances every cycle; the sequence is 0,1,...,CHANNELS-1,0,...
  - DWELL changed mid-dwell: the new value is compared immediately. If cnt > new DWELL, advance on the next cycle.
- SCAN->MANUAL: the next cycle follows S; the pointer is discarded.
- Input data is sampled at the clock edge. Input changes without a new edge do not alter O.

Optional Feature:
- Macro: MUX_SCAN_SKIP_EN.
- When defined:
  - Adds input port MASK (CHANNELS bits, 1 = channel enabled).
  - SCAN advances to the next enabled channel above the pointer, wrapping; disabled channels are never output.
  - Entering SCAN starts at the lowest enabled channel.
  - MASK all zero: VALID<=0, O holds, STEP=0.
  - MANUAL with MASK[S]=0: treated as out of range (ERR=1).
  - A MASK change takes effect at the next advance.
- When undefined: no MASK port; all channels are enabled; behaviour is exactly as above.

Decomposition:
- Package mux_scan_pkg:
  - state typedef (MANUAL, SCAN)
  - mode constants MODE_MANUAL=0 and MODE_SCAN=1
  - helper function for next pointer with wrap
- Sub-module mux_nbit_core: purely combinational, parametrised CHANNELS:1 WIDTH-bit selector, index input, in-range flag output.
- Top level holds the FSM, pointer, dwell counter and output registers.

Test Plan:
- Reset: RST=1 mid-SCAN at pointer 3 -> O=0, CH=0, VALID=0, ERR=0, STEP=0 asynchronously; after release with MODE=1, channel 0 is output.
- MANUAL: I ch2=3'b101, S=2 -> next edge O=5, CH=2, VALID=1; then S=6 -> O holds 5, VALID=0, ERR=1.
- SCAN with DWELL=2, ch k = k -> CH sequence 0,0,0,1,1,1,...,4,4,4,0; STEP pulses on the cycles leaving 0,1,2,3,4.
- SCAN with DWELL=0 -> CH is 0,1,2,3,4,0 on consecutive cycles; STEP=1 every cycle.
- HOLD=1 for 4 cycles while at CH=3, cnt=1 -> O, CH, cnt unchanged; the scan resumes its remaining dwell after HOLD drops.
- MUX_SCAN_SKIP_EN, MASK=5'b10101, DWELL=0 -> CH is 0,2,4,0; then MASK=0 -> VALID=0, O holds.
